// File: rtl/vz_pkg.sv
// Shared types and constants for the VZ snapshot loader.
// Latency: n/a (types, constants and one pure header-check function).
// Backpressure: n/a.
package vz_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_DRAIN,
      S_PATCH_LO,
      S_PATCH_HI,
      S_DONE,
      S_ERROR
   } vz_state_t;

   // "VZF" followed by a version byte of either "0" or "O"
   localparam logic [23:0] VZ_MAGIC   = 24'h565A46;
   localparam logic [7:0]  VZ_VER_0   = 8'h30;
   localparam logic [7:0]  VZ_VER_O   = 8'h4F;

   localparam logic [7:0]  TYPE_BASIC = 8'hF0;
   localparam logic [7:0]  TYPE_BIN   = 8'hF1;

   // Header byte offsets (bytes 4..20 hold the file name and are not checked)
   localparam int OFF_VER      = 3;
   localparam int OFF_TYPE     = 21;
   localparam int OFF_START_LO = 22;
   localparam int OFF_START_HI = 23;

   // True when byte b is acceptable at header offset off
   function automatic logic hdr_byte_ok(input logic [15:0] off, input logic [7:0] b);
      logic ok;
      ok = 1'b1;
      case (off)
         16'd0:           ok = (b == VZ_MAGIC[23:16]);
         16'd1:           ok = (b == VZ_MAGIC[15:8]);
         16'd2:           ok = (b == VZ_MAGIC[7:0]);
         16'(OFF_VER):    ok = (b == VZ_VER_0) || (b == VZ_VER_O);
         16'(OFF_TYPE):   ok = (b == TYPE_BASIC) || (b == TYPE_BIN);
         default:         ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/vz_byte_fifo.sv
// Small synchronous FIFO with flush; head entry is visible on dout combinationally.
// Latency: a push into an empty FIFO appears on dout the following cycle.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk_sys/reset (async, active-high), flush, push/din, pop/dout, full, empty, count.
module vz_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Simultaneous push and pop while full is fine: the slot being read is the
   // one being overwritten, and the read value is consumed this cycle.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || pop);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vz_image_loader.sv
// Parses a VZ snapshot from the ioctl download bus and writes its payload into system RAM.
// Latency: a payload byte reaches mem_* one cycle after its dn_wr strobe if the FIFO was empty.
// Backpressure: mem_ready low holds the head write; a push into a full FIFO with no pop is an error.
// Ports: dn_* download bus in; mem_addr/mem_wdata/mem_we/mem_ready RAM write port;
//        cpu_hold/busy/done/err status; img_type/exec_addr decoded header fields.
module vz_image_loader
   import vz_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int          HDR_LEN    = 24,
   parameter logic [7:0]  IMG_INDEX  = 8'd1,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] PTR_ADDR   = 16'h78F9
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dn_download,
   input  logic [7:0]        dn_index,
   input  logic              dn_wr,
   input  logic [15:0]       dn_addr,
   input  logic [7:0]        dn_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        img_type,
   output logic [ADDR_W-1:0] exec_addr
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   vz_state_t         state, state_nxt;
   logic              dl_q;
   logic              acc_dl, dl_rise, dl_fall, wr_acc, addr_ok;
   logic [16:0]       off;          // expected dn_addr; one spare bit so it cannot wrap
   logic [ADDR_W:0]   paddr;        // address of the next byte pushed; MSB flags overrun
   logic [ADDR_W-1:0] wr_addr;      // address of the FIFO head byte; end pointer after drain
   logic [7:0]        start_lo;
   logic [15:0]       start16;
   logic [15:0]       end16;

   logic              fifo_push, fifo_pop, fifo_flush;
   logic              fifo_full, fifo_empty;
   logic [7:0]        fifo_dout;
   logic [CNT_W-1:0]  fifo_count;

   logic              hdr_take, dl_start, err_set, fault;

   assign acc_dl  = dn_download && (dn_index == IMG_INDEX);
   assign dl_rise = acc_dl && !dl_q;
   assign dl_fall = dl_q && !dn_download;
   assign wr_acc  = dn_wr && acc_dl;
   assign addr_ok = ({1'b0, dn_addr} == off);
   assign start16 = {dn_data, start_lo};
   assign end16   = 16'(wr_addr);

   assign fifo_pop = ((state == S_PAYLOAD) || (state == S_DRAIN)) && !fifo_empty && mem_ready;

   assign cpu_hold = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_DRAIN) ||
                     (state == S_PATCH_LO) || (state == S_PATCH_HI);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

   vz_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .flush   (fifo_flush),
      .push    (fifo_push),
      .din     (dn_data),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      hdr_take   = 1'b0;
      dl_start   = 1'b0;
      err_set    = 1'b0;
      fault      = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = wr_addr;
      mem_wdata  = fifo_dout;

      case (state)
         S_PAYLOAD, S_DRAIN: mem_we = !fifo_empty;
         S_PATCH_LO: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(PTR_ADDR);
            mem_wdata = end16[7:0];
         end
         S_PATCH_HI: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(PTR_ADDR) + ADDR_W'(1);
            mem_wdata = end16[15:8];
         end
         default: ;
      endcase

      if (dl_rise) begin
         // A new accepted download always wins, whatever was in progress.
         state_nxt  = S_HEADER;
         fifo_flush = 1'b1;
         dl_start   = 1'b1;
      end else begin
         case (state)
            S_HEADER: begin
               if (dl_fall) begin
                  fault = 1'b1;
               end else if (wr_acc) begin
                  if (!addr_ok || !hdr_byte_ok(dn_addr, dn_data)) begin
                     fault = 1'b1;
                  end else begin
                     hdr_take = 1'b1;
                     if (dn_addr == 16'(HDR_LEN - 1)) state_nxt = S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (wr_acc && (!addr_ok || paddr[ADDR_W] || (fifo_full && !fifo_pop))) begin
                  fault = 1'b1;
               end else begin
                  fifo_push = wr_acc;
                  if (dl_fall) state_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_count == '0)
                  state_nxt = (img_type == TYPE_BASIC) ? S_PATCH_LO : S_DONE;
            end
            S_PATCH_LO: if (mem_ready) state_nxt = S_PATCH_HI;
            S_PATCH_HI: if (mem_ready) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            S_ERROR:    if (!dn_download) state_nxt = S_IDLE;
            default:    state_nxt = state;
         endcase
      end

      if (fault) begin
         state_nxt  = S_ERROR;
         err_set    = 1'b1;
         fifo_flush = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_q      <= 1'b0;
         err       <= 1'b0;
         off       <= '0;
         paddr     <= '0;
         wr_addr   <= '0;
         start_lo  <= '0;
         img_type  <= '0;
         exec_addr <= '0;
      end else begin
         dl_q <= acc_dl;
         if (dl_start) begin
            err <= 1'b0;
            off <= '0;
         end
         if (err_set) err <= 1'b1;
         if (hdr_take) begin
            off <= off + 17'd1;
            if (dn_addr == 16'(OFF_TYPE))     img_type <= dn_data;
            if (dn_addr == 16'(OFF_START_LO)) start_lo <= dn_data;
            if (dn_addr == 16'(OFF_START_HI)) begin
               exec_addr <= ADDR_W'(start16);
               wr_addr   <= ADDR_W'(start16);
               paddr     <= {1'b0, ADDR_W'(start16)};
            end
         end
         if (fifo_push) begin
            off   <= off + 17'd1;
            paddr <= paddr + (ADDR_W+1)'(1);
         end
         if (fifo_pop) wr_addr <= wr_addr + ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_vz_image_loader.sv
// Scoreboard bench for vz_image_loader: expected RAM writes are queued by the stimulus,
// a negedge monitor pops and compares every accepted write and counts done pulses.
module tb_vz_image_loader;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        dn_download = 1'b0;
   logic [7:0]  dn_index = 8'd0;
   logic        dn_wr = 1'b0;
   logic [15:0] dn_addr = 16'd0;
   logic [7:0]  dn_data = 8'd0;
   logic        mem_ready = 1'b1;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        cpu_hold, busy, done, err;
   logic [7:0]  img_type;
   logic [15:0] exec_addr;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          exp_done = 0;
   bit          busy_seen = 1'b0;
   logic [23:0] exp_q[$];

   vz_image_loader dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .dn_download (dn_download),
      .dn_index    (dn_index),
      .dn_wr       (dn_wr),
      .dn_addr     (dn_addr),
      .dn_data     (dn_data),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_ready   (mem_ready),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .img_type    (img_type),
      .exec_addr   (exec_addr)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted RAM write must match the head of the scoreboard.
   always @(negedge clk_sys) begin
      if (!reset) begin
         if (done) done_cnt++;
         if (busy) busy_seen = 1'b1;
         if (mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
            end else begin
               chk("ram_write", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic start_dl(input logic [7:0] idx);
      dn_index    = idx;
      dn_download = 1'b1;
      tick();
   endtask

   task automatic end_dl();
      dn_download = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
      dn_addr = a;
      dn_data = d;
      dn_wr   = 1'b1;
      tick();
      dn_wr   = 1'b0;
      tick();
   endtask

   // First n bytes of a header: "VZ", m2, "0", name, type, start lo/hi
   task automatic send_hdr(input logic [7:0] m2, input logic [7:0] t, input logic [15:0] st, input int n);
      logic [7:0] hb [24];
      hb[0] = 8'h56;
      hb[1] = 8'h5A;
      hb[2] = m2;
      hb[3] = 8'h30;
      for (int i = 4; i < 21; i++) hb[i] = 8'h41;
      hb[21] = t;
      hb[22] = st[7:0];
      hb[23] = st[15:8];
      for (int i = 0; i < n; i++) send_byte(16'(i), hb[i]);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   task automatic end_of_test(input string name);
      chk({name, "_sb_empty"}, exp_q.size(), 0);
      chk({name, "_done_cnt"}, done_cnt, exp_done);
      chk({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_mem_we", {31'd0, mem_we}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_hold", {31'd0, cpu_hold}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_type", {24'd0, img_type}, 0);
      chk("rst_exec", {16'd0, exec_addr}, 0);
      reset = 1'b0;
      tick();

      // F1 binary at 8000, three bytes
      exp_wr(16'h8000, 8'hAA); exp_wr(16'h8001, 8'hBB); exp_wr(16'h8002, 8'hCC);
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'h8000, 24);
      send_byte(16'd24, 8'hAA); send_byte(16'd25, 8'hBB); send_byte(16'd26, 8'hCC);
      chk("bin_hold_mid", {31'd0, cpu_hold}, 1);
      end_dl();
      exp_done++;
      wait_idle("bin_idle");
      end_of_test("bin");
      chk("bin_exec", {16'd0, exec_addr}, 32'h8000);
      chk("bin_type", {24'd0, img_type}, 32'hF1);
      chk("bin_err", {31'd0, err}, 0);

      // F0 BASIC at 7AE9, four bytes, end pointer 7AED patched
      exp_wr(16'h7AE9, 8'h01); exp_wr(16'h7AEA, 8'h02); exp_wr(16'h7AEB, 8'h03); exp_wr(16'h7AEC, 8'h04);
      exp_wr(16'h78F9, 8'hED); exp_wr(16'h78FA, 8'h7A);
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF0, 16'h7AE9, 24);
      for (int i = 0; i < 4; i++) send_byte(16'(24 + i), 8'(i + 1));
      end_dl();
      exp_done++;
      wait_idle("bas_idle");
      end_of_test("bas");
      chk("bas_err", {31'd0, err}, 0);

      // RAM stalled for 10+ cycles with three bytes buffered
      exp_wr(16'h4000, 8'h11); exp_wr(16'h4001, 8'h22); exp_wr(16'h4002, 8'h33);
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'h4000, 24);
      mem_ready = 1'b0;
      send_byte(16'd24, 8'h11); send_byte(16'd25, 8'h22); send_byte(16'd26, 8'h33);
      repeat (5) tick();
      chk("stall_pending", exp_q.size(), 3);
      chk("stall_err", {31'd0, err}, 0);
      mem_ready = 1'b1;
      end_dl();
      exp_done++;
      wait_idle("stall_idle");
      end_of_test("stall");

      // Empty BASIC payload: end pointer equals start
      exp_wr(16'h78F9, 8'hE9); exp_wr(16'h78FA, 8'h7A);
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF0, 16'h7AE9, 24);
      end_dl();
      exp_done++;
      wait_idle("empty_idle");
      end_of_test("empty");

      // FIFO overflow: fifth push with RAM stalled
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'h5000, 24);
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(16'(24 + i), 8'(8'h60 + i));
      chk("ovf_err", {31'd0, err}, 1);
      chk("ovf_busy", {31'd0, busy}, 1);
      chk("ovf_hold", {31'd0, cpu_hold}, 0);
      mem_ready = 1'b1;
      end_dl();
      wait_idle("ovf_idle");
      end_of_test("ovf");
      chk("ovf_err_sticky", {31'd0, err}, 1);

      // Bad magic "VZX0"
      start_dl(8'd1);
      chk("magic_err_clr", {31'd0, err}, 0);
      send_hdr(8'h58, 8'hF1, 16'h8000, 24);
      chk("magic_err", {31'd0, err}, 1);
      chk("magic_hold", {31'd0, cpu_hold}, 0);
      end_dl();
      wait_idle("magic_idle");
      end_of_test("magic");

      // Bad type byte 0x22
      start_dl(8'd1);
      chk("type_err_clr", {31'd0, err}, 0);
      send_hdr(8'h46, 8'h22, 16'h8000, 24);
      send_byte(16'd24, 8'h99);
      chk("type_err", {31'd0, err}, 1);
      end_dl();
      wait_idle("type_idle");
      end_of_test("type");

      // Foreign index: ignored entirely, err left as it was
      busy_seen = 1'b0;
      start_dl(8'd0);
      send_hdr(8'h46, 8'hF1, 16'h8000, 24);
      send_byte(16'd24, 8'h12);
      end_dl();
      repeat (3) tick();
      chk("idx0_busy", {31'd0, busy_seen}, 0);
      chk("idx0_err", {31'd0, err}, 1);
      end_of_test("idx0");

      // Restart while payload is still buffered: only the second image lands
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'h6000, 24);
      mem_ready = 1'b0;
      send_byte(16'd24, 8'h77); send_byte(16'd25, 8'h88);
      end_dl();
      dn_download = 1'b1;
      tick();
      mem_ready = 1'b1;
      chk("rst_hdr_hold", {31'd0, cpu_hold}, 1);
      exp_wr(16'h9000, 8'h55);
      send_hdr(8'h46, 8'hF1, 16'h9000, 24);
      send_byte(16'd24, 8'h55);
      end_dl();
      exp_done++;
      wait_idle("restart_idle");
      end_of_test("restart");
      chk("restart_exec", {16'd0, exec_addr}, 32'h9000);

      // Short file: download ends inside the header
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'h8000, 10);
      end_dl();
      chk("short_err", {31'd0, err}, 1);
      wait_idle("short_idle");
      end_of_test("short");

      // Top of memory: FFFE and FFFF written, third byte overruns
      exp_wr(16'hFFFE, 8'hD1); exp_wr(16'hFFFF, 8'hD2);
      start_dl(8'd1);
      send_hdr(8'h46, 8'hF1, 16'hFFFE, 24);
      send_byte(16'd24, 8'hD1); send_byte(16'd25, 8'hD2); send_byte(16'd26, 8'hD3);
      chk("top_err", {31'd0, err}, 1);
      end_dl();
      wait_idle("top_idle");
      end_of_test("top");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
